// File: rtl/sram_port_arbiter.sv
// Shares one sram-like memory port between instruction fetch and data access,
// with fixed data priority and in-order routing of responses back to each issuer.
module sram_port_arbiter #(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned PTR_W       = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned PW = (PTR_W > 0) ? PTR_W : 1;
    localparam logic [PTR_W:0] CNT_MAX  = (PTR_W + 1)'(OUTSTANDING);
    localparam logic [PW-1:0]  PTR_LAST = PW'(OUTSTANDING - 1);
    localparam logic TAG_INST = 1'b0;
    localparam logic TAG_DATA = 1'b1;

    typedef enum logic {S_IDLE, S_HOLD} state_e;

    state_e                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic [PTR_W:0]         cnt_q, cnt_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OUTSTANDING-1:0] tags_q, tags_d;

    logic req_c, grant_c, pop_c, push_c, full_c, head_c;

    always_comb begin
        pop_c   = mem_data_ok && (cnt_q != '0);
        // A same-cycle pop frees a slot, so a full FIFO can still accept.
        full_c  = (cnt_q == CNT_MAX) && !pop_c;
        head_c  = tags_q[rd_ptr_q];
        state_d = state_q;
        owner_d = owner_q;
        req_c   = 1'b0;
        grant_c = TAG_INST;
        case (state_q)
            S_IDLE: begin
                if (!full_c) begin
                    if (data_sram_req) begin
                        req_c   = 1'b1;
                        grant_c = TAG_DATA;
                    end else if (inst_sram_req) begin
                        req_c   = 1'b1;
                        grant_c = TAG_INST;
                    end
                end
                if (req_c && !mem_addr_ok) begin
                    state_d = S_HOLD;
                    owner_d = grant_c;
                end
            end
            S_HOLD: begin
                req_c   = 1'b1;
                grant_c = owner_q;
                if (mem_addr_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        push_c = req_c && mem_addr_ok;

        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            tags_d[wr_ptr_q] = grant_c;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_c) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        cnt_d = cnt_q + {{PTR_W{1'b0}}, push_c} - {{PTR_W{1'b0}}, pop_c};
    end

    always_comb begin
        mem_req           = 1'b0;
        mem_wr            = 1'b0;
        mem_size          = '0;
        mem_wstrb         = '0;
        mem_addr          = '0;
        mem_wdata         = '0;
        inst_sram_addr_ok = 1'b0;
        data_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        inst_sram_rdata   = '0;
        data_sram_rdata   = '0;
        if (resetn) begin
            mem_req = req_c;
            if (req_c && grant_c == TAG_DATA) begin
                mem_wr    = data_sram_wr;
                mem_size  = data_sram_size;
                mem_wstrb = data_sram_wstrb;
                mem_addr  = data_sram_addr;
                mem_wdata = data_sram_wdata;
            end else if (req_c) begin
                mem_size  = inst_sram_size;
                mem_addr  = inst_sram_addr;
            end
            inst_sram_addr_ok = push_c && (grant_c == TAG_INST);
            data_sram_addr_ok = push_c && (grant_c == TAG_DATA);
            inst_sram_data_ok = pop_c && (head_c == TAG_INST);
            data_sram_data_ok = pop_c && (head_c == TAG_DATA);
            inst_sram_rdata   = mem_rdata;
            data_sram_rdata   = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            owner_q  <= TAG_INST;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tags_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tags_q   <= tags_d;
        end
    end

    // A response with nothing outstanding is dropped; flag it in simulation.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
        mem_data_ok |-> (cnt_q != '0))
        else $error("sram_port_arbiter: mem_data_ok with no outstanding transaction");
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based model of grant, owner order and response routing.
module tb_sram_port_arbiter;
    localparam int unsigned OUT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_rdata;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    // Model: issue-ordered owner queue (0 = inst, 1 = data) and address-phase lock.
    bit oq[$];
    bit locked = 1'b0;
    bit lock_owner = 1'b0;
    bit m_acc_inst, m_acc_data, m_pop;

    sram_port_arbiter #(.OUTSTANDING(OUT), .PTR_W(1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with inputs applied; checks this cycle and
    // advances the model to the state after the coming posedge.
    task automatic model_step();
        bit req, grant, pop, acc;
        #1;
        m_acc_inst = 1'b0;
        m_acc_data = 1'b0;
        m_pop      = 1'b0;
        if (!resetn) begin
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_fields", {25'd0, mem_wr, mem_size, mem_wstrb}, 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_oks", {28'd0, inst_sram_addr_ok, data_sram_addr_ok,
                            inst_sram_data_ok, data_sram_data_ok}, 32'd0);
            chk("rst_rdata", inst_sram_rdata | data_sram_rdata, 32'd0);
            oq.delete();
            locked = 1'b0;
            return;
        end
        pop   = mem_data_ok && (oq.size() > 0);
        req   = 1'b0;
        grant = 1'b0;
        if (locked) begin
            req = 1'b1; grant = lock_owner;
        end else if (!(oq.size() == OUT && !pop)) begin
            if (data_sram_req)      begin req = 1'b1; grant = 1'b1; end
            else if (inst_sram_req) begin req = 1'b1; grant = 1'b0; end
        end
        acc = req && mem_addr_ok;
        chk("mem_req", 32'(mem_req), 32'(req));
        chk("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(acc && !grant));
        chk("data_addr_ok", 32'(data_sram_addr_ok), 32'(acc && grant));
        chk("inst_data_ok", 32'(inst_sram_data_ok), 32'(pop && oq[0] == 1'b0));
        chk("data_data_ok", 32'(data_sram_data_ok), 32'(pop && oq[0] == 1'b1));
        chk("inst_rdata", inst_sram_rdata, mem_rdata);
        chk("data_rdata", data_sram_rdata, mem_rdata);
        if (req) begin
            chk("mem_addr", mem_addr, grant ? data_sram_addr : inst_sram_addr);
            chk("mem_wr", 32'(mem_wr), grant ? 32'(data_sram_wr) : 32'd0);
            chk("mem_size", 32'(mem_size), grant ? 32'(data_sram_size) : 32'(inst_sram_size));
            chk("mem_wstrb", 32'(mem_wstrb), grant ? 32'(data_sram_wstrb) : 32'd0);
            chk("mem_wdata", mem_wdata, grant ? data_sram_wdata : 32'd0);
        end
        if (pop) void'(oq.pop_front());
        if (acc) oq.push_back(grant);
        if (locked) begin
            if (mem_addr_ok) locked = 1'b0;
        end else if (req && !mem_addr_ok) begin
            locked = 1'b1; lock_owner = grant;
        end
        m_acc_inst = acc && !grant;
        m_acc_data = acc && grant;
        m_pop      = pop;
    endtask

    task automatic cyc(input bit rn, input bit ir, input bit dr, input bit aok,
                       input bit dok, input logic [31:0] rd);
        resetn        = rn;
        inst_sram_req = ir;
        data_sram_req = dr;
        mem_addr_ok   = aok;
        mem_data_ok   = dok;
        mem_rdata     = rd;
        model_step();
    endtask

    task automatic set_data(input bit wr, input logic [1:0] sz, input logic [3:0] st,
                            input logic [31:0] a, input logic [31:0] wd);
        data_sram_wr = wr; data_sram_size = sz; data_sram_wstrb = st;
        data_sram_addr = a; data_sram_wdata = wd;
    endtask

    initial begin
        int  pend;
        bit  i_act, d_act;
        resetn = 1'b0; inst_sram_req = 1'b0; data_sram_req = 1'b0;
        inst_sram_size = 2'b10; inst_sram_addr = '0;
        set_data(1'b0, 2'd2, 4'hF, 32'h0, 32'h0);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

        // Reset state
        @(negedge clk); cyc(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk); cyc(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk); cyc(1, 0, 0, 0, 0, 32'h0);

        // Single fetch
        @(negedge clk); inst_sram_addr = 32'h1C00_0000;
        cyc(1, 1, 0, 1, 0, 32'h0);
        chk("t1_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        @(negedge clk); cyc(1, 0, 0, 0, 1, 32'h0280_0000);
        chk("t1_inst_data_ok", 32'(inst_sram_data_ok), 32'd1);
        chk("t1_inst_rdata", inst_sram_rdata, 32'h0280_0000);
        chk("t1_data_data_ok", 32'(data_sram_data_ok), 32'd0);
        @(negedge clk); cyc(1, 0, 0, 0, 0, 32'h0);

        // Contention: data wins, inst follows, responses routed in issue order
        @(negedge clk); inst_sram_addr = 32'h1C00_0004;
        set_data(1'b0, 2'd2, 4'hF, 32'h1C00_1000, 32'h0);
        cyc(1, 1, 1, 1, 0, 32'h0);
        chk("t2_mem_addr", mem_addr, 32'h1C00_1000);
        chk("t2_data_addr_ok", 32'(data_sram_addr_ok), 32'd1);
        @(negedge clk); cyc(1, 1, 0, 1, 0, 32'h0);
        chk("t2_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        @(negedge clk); cyc(1, 0, 0, 0, 1, 32'hAAAA_0000);
        chk("t2_data_data_ok", 32'(data_sram_data_ok), 32'd1);
        @(negedge clk); cyc(1, 0, 0, 0, 1, 32'h5555_FFFF);
        chk("t2_inst_data_ok", 32'(inst_sram_data_ok), 32'd1);
        chk("t2_inst_rdata", inst_sram_rdata, 32'h5555_FFFF);

        // Hold: the stalled inst grant is not pre-empted by a later data request
        @(negedge clk); inst_sram_addr = 32'h1C00_0008;
        set_data(1'b0, 2'd2, 4'hF, 32'h1C00_1004, 32'h0);
        cyc(1, 1, 0, 0, 0, 32'h0);
        @(negedge clk); cyc(1, 1, 1, 0, 0, 32'h0);
        chk("t3_hold_addr_c2", mem_addr, 32'h1C00_0008);
        @(negedge clk); cyc(1, 1, 1, 0, 0, 32'h0);
        chk("t3_hold_addr_c3", mem_addr, 32'h1C00_0008);
        @(negedge clk); cyc(1, 1, 1, 1, 0, 32'h0);
        chk("t3_inst_accept", 32'(inst_sram_addr_ok), 32'd1);
        chk("t3_data_waits", 32'(data_sram_addr_ok), 32'd0);
        @(negedge clk); cyc(1, 0, 1, 1, 0, 32'h0);
        chk("t3_data_accept", 32'(data_sram_addr_ok), 32'd1);
        @(negedge clk); cyc(1, 0, 0, 0, 1, 32'h1111_1111);
        @(negedge clk); cyc(1, 0, 0, 0, 1, 32'h2222_2222);
        chk("t3_data_data_ok", 32'(data_sram_data_ok), 32'd1);

        // Full: two outstanding blocks further requests unless a pop coincides
        @(negedge clk); inst_sram_addr = 32'h1C00_000C;
        set_data(1'b0, 2'd2, 4'hF, 32'h1C00_3000, 32'h0);
        cyc(1, 1, 1, 1, 0, 32'h0);
        @(negedge clk); set_data(1'b0, 2'd2, 4'hF, 32'h1C00_3004, 32'h0);
        cyc(1, 1, 1, 1, 0, 32'h0);
        @(negedge clk); set_data(1'b0, 2'd2, 4'hF, 32'h1C00_3008, 32'h0);
        cyc(1, 1, 1, 1, 0, 32'h0);
        chk("t4_full_no_req", 32'(mem_req), 32'd0);
        @(negedge clk); cyc(1, 1, 1, 1, 1, 32'h3333_0000);
        chk("t4_pop_push_accept", 32'(data_sram_addr_ok), 32'd1);
        chk("t4_pop_data_ok", 32'(data_sram_data_ok), 32'd1);
        @(negedge clk); cyc(1, 1, 0, 1, 0, 32'h0);
        chk("t4_still_full", 32'(mem_req), 32'd0);
        @(negedge clk); cyc(1, 1, 0, 1, 1, 32'h3333_0001);
        chk("t4_inst_after_pop", 32'(inst_sram_addr_ok), 32'd1);
        @(negedge clk); cyc(1, 0, 0, 0, 1, 32'h3333_0002);
        @(negedge clk); cyc(1, 0, 0, 0, 1, 32'h3333_0003);
        chk("t4_inst_last", 32'(inst_sram_data_ok), 32'd1);

        // Store
        @(negedge clk); set_data(1'b1, 2'd1, 4'b0011, 32'h1C00_2002, 32'h1234_5678);
        cyc(1, 0, 1, 1, 0, 32'h0);
        chk("t5_mem_wr", 32'(mem_wr), 32'd1);
        chk("t5_mem_wstrb", 32'(mem_wstrb), 32'h3);
        chk("t5_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("t5_mem_addr", mem_addr, 32'h1C00_2002);
        @(negedge clk); cyc(1, 0, 0, 0, 1, 32'h0);
        chk("t5_store_done", 32'(data_sram_data_ok), 32'd1);

        // Reset with two in flight, then a clean fetch
        @(negedge clk); set_data(1'b0, 2'd2, 4'hF, 32'h1C00_4000, 32'h0);
        inst_sram_addr = 32'h1C00_0010;
        cyc(1, 1, 1, 1, 0, 32'h0);
        @(negedge clk); cyc(1, 1, 0, 1, 0, 32'h0);
        @(negedge clk); cyc(0, 1, 1, 1, 1, 32'hDEAD_BEEF);
        @(negedge clk); cyc(1, 0, 0, 0, 0, 32'h0);
        @(negedge clk); inst_sram_addr = 32'h1C00_0000;
        cyc(1, 1, 0, 1, 0, 32'h0);
        @(negedge clk); cyc(1, 0, 0, 0, 1, 32'h0280_0000);
        chk("t6_fresh_inst_ok", 32'(inst_sram_data_ok), 32'd1);
        chk("t6_no_stale_data", 32'(data_sram_data_ok), 32'd0);

        // Randomized traffic; requesters hold their fields until addr_ok
        pend = 0; i_act = 1'b0; d_act = 1'b0;
        repeat (600) begin
            @(negedge clk);
            resetn = 1'b1;
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1'b1;
                inst_sram_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1'b1;
                set_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                         4'($urandom), $urandom, $urandom);
            end
            inst_sram_req = i_act;
            data_sram_req = d_act;
            mem_data_ok   = (pend > 0) && ($urandom_range(0, 1) == 1);
            mem_addr_ok   = ($urandom_range(0, 4) < 3);
            mem_rdata     = $urandom;
            model_step();
            if (m_pop) pend--;
            if (m_acc_inst || m_acc_data) pend++;
            if (m_acc_inst) i_act = 1'b0;
            if (m_acc_data) d_act = 1'b0;
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
